dram_ctrl030: RTL
=================

Name: dram_ctrl030

Overview:
- DRAM controller for the 68030 RAM slot; sequences RAS/row-col mux/CAS/WE for CPU accesses and periodic CAS-before-RAS refresh, arbitrating the shared DRAM array between the CPU and the refresh timer.
- Per-lane CAS comes from the active-low byte selects produced by the bus select decoder: all four lanes are asserted on reads; only the addressed lanes are asserted on writes.
- Terminates CPU cycles as a 32-bit port.

Parameters:
REFRESH_INTERVAL, 390, sysClk cycles between refresh requests (15.6 us at 25 MHz)
PRECHARGE_CYCLES, 2, cycles RAS and CAS held negated after any DRAM cycle (min 1)
CAS_CYCLES, 2, cycles CAS held before DSACK is allowed to assert (min 1)
REF_RAS_CYCLES, 3, cycles RAS held low during refresh (min 1)

Ports:
sysClk  in  1  system clock, same clock as the CPU
sysRst  in  1  asynchronous, active-high reset
cpuASn  in  1  CPU address strobe, active low
ramSELn  in  1  address decode for the RAM region, active low
cpuRWn  in  1  CPU read/write (1 = read)
byteSELn  in  4  active-low byte-lane selects; [3] = D31:24
ramRASn  out  1  DRAM row strobe, active low
ramCASn  out  4  DRAM column strobes per lane, active low
ramWEn  out  1  DRAM write enable, active low
ramMuxSel  out  1  address mux select: 0 = row, 1 = column
cpuDSACKn  out  2  CPU data-size acknowledge, active low
cpuSTERMn  out  1  synchronous termination, active low (driven only with feature enabled)

Behaviour:
- All inputs are sampled on the rising edge of sysClk. All outputs are registered.
- Reset values (async on sysRst=1): ramRASn=1, ramCASn=4'hF, ramWEn=1, ramMuxSel=0, cpuDSACKn=2'b11, cpuSTERMn=1, state IDLE, refresh counter loaded with REFRESH_INTERVAL-1, refPending=0.
- Refresh timer:
  - Down-counter; on reaching 0 it sets refPending and reloads.
  - refPending clears on entry to REF_CAS.
  - A tick that arrives while refPending=1 is dropped; the flag saturates.
- States:
  - IDLE:
    - If refPending: go to REF_CAS. Refresh wins when it coincides with a new access.
    - Else if cpuASn=0 and ramSELn=0: go to RAS and latch cpuRWn.
    - Else stay in IDLE.
  - RAS: ramRASn=0, ramMuxSel=0. Next state COL.
  - COL: ramMuxSel=1. Next state CAS.
  - CAS:
    - ramCASn = byteSELn.
    - ramWEn = latched cpuRWn, so WE is asserted (0) for writes.
    - Held for CAS_CYCLES cycles, then go to TERM.
  - TERM:
    - cpuDSACKn=2'b00; RAS and CAS remain asserted.
    - Hold until cpuASn=1, then go to PRE.
  - PRE:
    - All strobes, WE and DSACK negated; ramMuxSel=0.
    - Held for PRECHARGE_CYCLES cycles, then go to IDLE.
  - REF_CAS: ramCASn=4'h0 with ramRASn=1 and ramWEn=1, for 1 cycle. Next state REF_RAS.
  - REF_RAS: ramRASn=0, CAS stays low, for REF_RAS_CYCLES cycles. Next state PRE.
- Access abort: if cpuASn negates while in RAS, COL or CAS, go directly to PRE. DSACK is never asserted for an aborted cycle.
- CPU latency: with defaults, DSACK asserts on the 5th rising edge after the edge that sampled cpuASn low.
- Back-to-back accesses: a new access is accepted only from IDLE, i.e. after precharge completes.
- Counters are sized by $clog2 of their parameter; the refresh counter keeps running in every state.
- Reset asserted mid-cycle forces the reset values immediately; no partial refresh is recorded.

Optional Feature:
- Macro: DRAM_STERM_EN.
- Defined:
  - Cycles terminate with cpuSTERMn=0 for exactly one cycle, on the last CAS cycle (replacing TERM's DSACK).
  - cpuDSACKn stays 2'b11.
  - TERM then only waits for cpuASn=1.
- Undefined: cpuSTERMn is tied to 1 and DSACK termination is used as described above.

Decomposition:
- Package dram030_pkg holds:
  - the state enum (IDLE, RAS, COL, CAS, TERM, PRE, REF_CAS, REF_RAS);
  - the DSACK encoding constants (DSACK_32=2'b00, DSACK_NONE=2'b11);
  - the default timing constants.
- Sub-module dram_refresh_timer contains the interval counter and the refPending flag, with a clear-on-grant input.

Test Plan:
- Read, byteSELn=4'h0, defaults:
  - RAS falls at edge 1 after AS sampled low; ramMuxSel=1 at edge 2; ramCASn=4'h0 at edge 3; cpuDSACKn=00 at edge 5.
  - After AS negates: 2 precharge cycles, then IDLE.
- Byte write, cpuRWn=0, byteSELn=4'b0111: ramCASn=4'b0111 and ramWEn=0 during CAS; other lanes stay high.
- Refresh with REFRESH_INTERVAL=16, no CPU traffic: ramCASn=4'h0 falls one cycle before ramRASn; RAS low for 3 cycles; repeats every 16 clocks.
- Refresh tick coincident with AS on an idle edge: refresh sequence runs first; the CPU access starts after precharge; DSACK is delayed accordingly.
- AS negated during COL: no CAS pulse, DSACK stays 11, PRE is entered; the next access completes normally.
- sysRst pulsed during REF_RAS: all outputs return to reset values asynchronously; first refresh after release occurs REFRESH_INTERVAL clocks later. With DRAM_STERM_EN, the read scenario shows a 1-cycle STERMn pulse and DSACK held at 11.

Source files
------------

// File: rtl/dram030_pkg.sv
// dram030_pkg: shared state type, DSACK codes and default timing
// for the 68030 DRAM slot controller.
package dram030_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RAS,
      COL,
      CAS,
      TERM,
      PRE,
      REF_CAS,
      REF_RAS
   } dram_state_e;

   localparam logic [1:0] DSACK_32   = 2'b00;
   localparam logic [1:0] DSACK_NONE = 2'b11;

   localparam int DEF_REFRESH_INTERVAL = 390;
   localparam int DEF_PRECHARGE_CYCLES = 2;
   localparam int DEF_CAS_CYCLES       = 2;
   localparam int DEF_REF_RAS_CYCLES   = 3;

   // Counter width able to hold n-1, never below one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: free-running refresh interval counter with a
// saturating request flag cleared when the controller grants refresh.
module dram_refresh_timer
   import dram030_pkg::*;
#(
   parameter int INTERVAL = DEF_REFRESH_INTERVAL
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic pending_o
);

   localparam int            CW     = cnt_width(INTERVAL);
   localparam logic [CW-1:0] RELOAD = CW'(INTERVAL - 1);

   logic [CW-1:0] cnt_q;
   logic          pend_q;

   // Count down every cycle; a tick while a request waits is dropped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= RELOAD;
         pend_q <= 1'b0;
      end else begin
         if (cnt_q == '0) begin
            cnt_q <= RELOAD;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (clr_i) begin
            pend_q <= 1'b0;
         end else if (cnt_q == '0) begin
            pend_q <= 1'b1;
         end
      end
   end

   assign pending_o = pend_q;

endmodule

// File: rtl/dram_ctrl030.sv
// dram_ctrl030: RAS/CAS sequencer and refresh arbiter for the 68030 RAM
// slot. Define DRAM_STERM_EN to terminate with STERMn instead of DSACKn.
module dram_ctrl030
   import dram030_pkg::*;
#(
   parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
   parameter int PRECHARGE_CYCLES = DEF_PRECHARGE_CYCLES,
   parameter int CAS_CYCLES       = DEF_CAS_CYCLES,
   parameter int REF_RAS_CYCLES   = DEF_REF_RAS_CYCLES
) (
   input  logic       sysClk,
   input  logic       sysRst,
   input  logic       cpuASn,
   input  logic       ramSELn,
   input  logic       cpuRWn,
   input  logic [3:0] byteSELn,
   output logic       ramRASn,
   output logic [3:0] ramCASn,
   output logic       ramWEn,
   output logic       ramMuxSel,
   output logic [1:0] cpuDSACKn,
   output logic       cpuSTERMn
);

   localparam int MAX_A = (PRECHARGE_CYCLES > CAS_CYCLES) ?
                          PRECHARGE_CYCLES : CAS_CYCLES;
   localparam int MAX_C = (MAX_A > REF_RAS_CYCLES) ?
                          MAX_A : REF_RAS_CYCLES;
   localparam int CW    = cnt_width(MAX_C);

   localparam logic [CW-1:0] PRE_LD = CW'(PRECHARGE_CYCLES - 1);
   localparam logic [CW-1:0] CAS_LD = CW'(CAS_CYCLES - 1);
   localparam logic [CW-1:0] REF_LD = CW'(REF_RAS_CYCLES - 1);

   dram_state_e state_q;
   logic [CW-1:0] cnt_q;
   logic          rw_q;
   logic          ras_q;
   logic [3:0]    cas_q;
   logic          we_q;
   logic          mux_q;
   logic [1:0]    dsack_q;
   logic          ref_pend;
   logic          ref_grant;
   logic          as_gone;

   assign ref_grant = (state_q == IDLE) && ref_pend;
   assign as_gone   = cpuASn && (state_q inside {RAS, COL, CAS, TERM});

   dram_refresh_timer #(
      .INTERVAL(REFRESH_INTERVAL)
   ) u_timer (
      .clk_i    (sysClk),
      .rst_i    (sysRst),
      .clr_i    (ref_grant),
      .pending_o(ref_pend)
   );

`ifdef DRAM_STERM_EN
   logic sterm_q;

   // One-cycle synchronous termination on the last CAS cycle.
   always_ff @(posedge sysClk or posedge sysRst) begin
      if (sysRst) begin
         sterm_q <= 1'b1;
      end else begin
         sterm_q <= !((state_q == CAS) && !cpuASn && (cnt_q == '0));
      end
   end

   assign cpuSTERMn = sterm_q;
`else
   assign cpuSTERMn = 1'b1;
`endif

   // Main sequencer; strobes are registered from the current state.
   always_ff @(posedge sysClk or posedge sysRst) begin
      if (sysRst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b1;
         ras_q   <= 1'b1;
         cas_q   <= 4'hF;
         we_q    <= 1'b1;
         mux_q   <= 1'b0;
         dsack_q <= DSACK_NONE;
      end else if (as_gone) begin
         ras_q   <= 1'b1;
         cas_q   <= 4'hF;
         we_q    <= 1'b1;
         mux_q   <= 1'b0;
         dsack_q <= DSACK_NONE;
         state_q <= PRE;
         cnt_q   <= PRE_LD;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ref_pend) begin
                  state_q <= REF_CAS;
               end else if (!cpuASn && !ramSELn) begin
                  state_q <= RAS;
                  rw_q    <= cpuRWn;
               end
            end
            RAS: begin
               ras_q   <= 1'b0;
               mux_q   <= 1'b0;
               state_q <= COL;
            end
            COL: begin
               mux_q   <= 1'b1;
               state_q <= CAS;
               cnt_q   <= CAS_LD;
            end
            CAS: begin
               cas_q <= byteSELn;
               we_q  <= rw_q;
               if (cnt_q == '0) begin
                  state_q <= TERM;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            TERM: begin
`ifndef DRAM_STERM_EN
               dsack_q <= DSACK_32;
`endif
            end
            PRE: begin
               ras_q   <= 1'b1;
               cas_q   <= 4'hF;
               we_q    <= 1'b1;
               mux_q   <= 1'b0;
               dsack_q <= DSACK_NONE;
               if (cnt_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            REF_CAS: begin
               cas_q   <= 4'h0;
               ras_q   <= 1'b1;
               we_q    <= 1'b1;
               state_q <= REF_RAS;
               cnt_q   <= REF_LD;
            end
            REF_RAS: begin
               ras_q <= 1'b0;
               if (cnt_q == '0) begin
                  state_q <= PRE;
                  cnt_q   <= PRE_LD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   assign ramRASn   = ras_q;
   assign ramCASn   = cas_q;
   assign ramWEn    = we_q;
   assign ramMuxSel = mux_q;
   assign cpuDSACKn = dsack_q;

endmodule
